sm4_key_expand: RTL and testbench
=================================

Name: sm4_key_expand

Overview:
- Produces the SM4 round keys consumed by the round-function stage. The round-function stage takes rk1 (encryption key) and rk2 (decryption key) plus a 6-bit round count.
- Takes a 128-bit master key and runs the SM4 key schedule, one round key per clock, for 32 clocks. Stores all 32 keys in an internal register file.
- Serves a registered read port indexed by the round count. It returns the encryption key and the decryption key (reverse order) together.

Parameters:
- ROUNDS, 32, number of round keys generated and stored (fixed by SM4; not intended to be changed)

Ports:
- K_clk  input  1  block clock, rising edge
- K_rst  input  1  asynchronous, active-high reset
- K_start  input  1  1-cycle pulse: latch key_in and start expansion
- key_in  input  [0:127]  master key MK0..MK3; bit 0 is the MSB, MK0 = key_in[0:31]
- rd_idx  input  [0:5]  round index from the round counter (count signal)
- K_busy  output  1  high while expansion is running
- K_done  output  1  high when all 32 keys are valid; level signal
- rk1  output  [0:31]  encryption round key rk[rd_idx], registered
- rk2  output  [0:31]  decryption round key rk[31-rd_idx], registered

Behaviour:
- Reset (asynchronous, K_rst=1):
  - state=IDLE, round counter=0, K_busy=0, K_done=0, rk1=0, rk2=0.
  - Register file contents are don't-care because outputs are gated by K_done.
- States and transitions:
  - IDLE: wait for K_start.
  - EXPAND: 32 clocks, counter i = 0..31.
  - READY: keys valid; serve reads.
  - IDLE or READY, on K_start=1 at edge E:
    - K0..K3 <= MK0^A3B1BAC6, MK1^56AA3350, MK2^677D9197, MK3^B27022DC.
    - i <= 0; K_done <= 0; K_busy <= 1; state <= EXPAND.
  - EXPAND, each edge:
    - rk[i] <= K0 ^ T'(K1^K2^K3^CK_i).
    - Shift: K0<=K1, K1<=K2, K2<=K3, K3<=new rk.
    - i <= i+1.
    - On the edge where i=31 is written: state <= READY, K_busy <= 0, K_done <= 1.
  - Timing: K_start at edge E → rk[0] written at E+1, rk[31] at E+32, K_done=1 from E+32. Latency is exactly 32 clocks.
  - K_start during EXPAND is ignored; the in-flight expansion completes with the original key.
  - K_start in READY restarts expansion: K_done drops at the next edge and the old keys are discarded.
- Datapath rules:
  - CK_i byte j (j=0 is MSB) = ((4*i + j) * 7) mod 256, computed in 8-bit arithmetic from the counter. No constant ROM.
  - T'(x) = L'(τ(x)). τ applies the SM4 S-box to each of the 4 bytes (4 parallel byte lookups, same table as the round function).
  - L'(B) = B ^ (B<<<13) ^ (B<<<23), 32-bit rotate-left.
  - Expansion is combinational within one clock; there is no pipelining inside a round.
- Read port:
  - Registered, 1-cycle latency: rk1/rk2 at edge N reflect rd_idx sampled at edge N.
  - If K_done=1 and rd_idx<32: rk1 <= rk[rd_idx], rk2 <= rk[31-rd_idx] (5-bit subtraction).
  - If rd_idx>=32 or K_done=0 (including during EXPAND): rk1 <= 0, rk2 <= 0.
- Counter width: internal i is 5 bits. The transition out of EXPAND is decided on i==31, not on overflow. The counter does not wrap back into EXPAND.
- Reset mid-expansion: immediate abort to IDLE with all outputs 0. A new K_start is required.

Test Plan:
- Standard vector: key_in=0123456789ABCDEFFEDCBA9876543210, K_start pulse → K_done rises exactly 32 clocks later. Then rd_idx=0 → rk1=F12186F9, rk2=9124A012. rd_idx=1 → rk1=41662B61. rd_idx=31 → rk1=9124A012, rk2=F12186F9.
- Sweep rd_idx 0..31 after done: rk1 sequence equals the reference-model key list. rk2 is the same list reversed. rd_idx=32 and rd_idx=63 → rk1=rk2=0.
- Reads before and during expansion (rd_idx=5 each cycle) → rk1=rk2=0 and K_busy=1 for all 32 cycles. K_done stays 0 until the final write.
- K_start re-pulsed at cycle 10 of expansion with key_in=all zeros → ignored; results still match the standard vector. A second K_start in READY with all-zero key → K_done low for 32 clocks, then keys match the all-zero-key model.
- K_rst asserted asynchronously mid-cycle at expansion round 17 → K_busy, K_done, rk1, rk2 go to 0 without waiting for a clock edge. After release, no activity until K_start; a full restart gives correct keys.
- Back-to-back: K_start on the same edge K_done rises → expansion restarts cleanly, K_done=0 next edge, total 32 clocks to the new K_done.

Source files
------------

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock,
// and serves encryption/decryption key pairs through a registered read port.
module sm4_key_expand #(
    parameter int unsigned ROUNDS = 32
) (
    input  logic         K_clk,
    input  logic         K_rst,
    input  logic         K_start,
    input  logic [0:127] key_in,
    input  logic [0:5]   rd_idx,
    output logic         K_busy,
    output logic         K_done,
    output logic [0:31]  rk1,
    output logic [0:31]  rk2
);

    localparam logic [4:0]  LAST = 5'(ROUNDS - 1);
    localparam logic [31:0] FK0  = 32'ha3b1bac6;
    localparam logic [31:0] FK1  = 32'h56aa3350;
    localparam logic [31:0] FK2  = 32'h677d9197;
    localparam logic [31:0] FK3  = 32'hb27022dc;

    // S-box packed row-major, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_BITS = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_BITS[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK byte j of round i is ((4i + j) * 7) mod 256; 8-bit arithmetic wraps naturally.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = ({1'b0, i, 2'b00} + 8'(j)) * 8'd7;
            w = {w[23:0], b};
        end
        return w;
    endfunction

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] rk_mem [ROUNDS];
    logic [31:0] rk_new;
    logic [31:0] mk0, mk1, mk2, mk3;
    logic [4:0]  rd_fwd, rd_rev;
    logic        rd_ok;

    assign mk0    = key_in[0:31];
    assign mk1    = key_in[32:63];
    assign mk2    = key_in[64:95];
    assign mk3    = key_in[96:127];
    assign rk_new = k0 ^ l_prime(tau(k1 ^ k2 ^ k3 ^ ck_word(cnt)));

    assign rd_ok  = K_done && !rd_idx[0];
    assign rd_fwd = rd_idx[1:5];
    assign rd_rev = LAST - rd_fwd;

    always_ff @(posedge K_clk or posedge K_rst) begin
        if (K_rst) begin
            state  <= StIdle;
            cnt    <= '0;
            K_busy <= 1'b0;
            K_done <= 1'b0;
            k0     <= '0;
            k1     <= '0;
            k2     <= '0;
            k3     <= '0;
            rk1    <= '0;
            rk2    <= '0;
        end else begin
            case (state)
                StIdle, StReady: begin
                    if (K_start) begin
                        k0     <= mk0 ^ FK0;
                        k1     <= mk1 ^ FK1;
                        k2     <= mk2 ^ FK2;
                        k3     <= mk3 ^ FK3;
                        cnt    <= '0;
                        K_done <= 1'b0;
                        K_busy <= 1'b1;
                        state  <= StExpand;
                    end
                end
                StExpand: begin
                    k0  <= k1;
                    k1  <= k2;
                    k2  <= k3;
                    k3  <= rk_new;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state  <= StReady;
                        K_busy <= 1'b0;
                        K_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (rd_ok) begin
                rk1 <= rk_mem[rd_fwd];
                rk2 <= rk_mem[rd_rev];
            end else begin
                rk1 <= '0;
                rk2 <= '0;
            end
        end
    end

    // Key storage needs no reset: reads are gated by K_done.
    always_ff @(posedge K_clk) begin
        if (state == StExpand) begin
            rk_mem[cnt] <= rk_new;
        end
    end

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand: standard SM4 vector, read-port sweeps, restarts,
// back-to-back expansion and asynchronous reset.
module tb_sm4_key_expand;

    localparam logic [127:0] STD_KEY  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ZERO_KEY = '0;

    localparam logic [2047:0] SBOX_ALL = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         K_clk;
    logic         K_rst;
    logic         K_start;
    logic [0:127] key_in;
    logic [0:5]   rd_idx;
    logic         K_busy;
    logic         K_done;
    logic [0:31]  rk1;
    logic [0:31]  rk2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_std  [32];
    logic [31:0] exp_zero [32];

    sm4_key_expand #(.ROUNDS(32)) dut (
        .K_clk  (K_clk),
        .K_rst  (K_rst),
        .K_start(K_start),
        .key_in (key_in),
        .rd_idx (rd_idx),
        .K_busy (K_busy),
        .K_done (K_done),
        .rk1    (rk1),
        .rk2    (rk2)
    );

    initial begin
        K_clk = 1'b0;
        forever #5 K_clk = ~K_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_ALL >> (8 * (255 - int'(x)));
        return t[7:0];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Textbook SM4 schedule over K[0..35].
    task automatic build_model(input logic [127:0] mk, output logic [31:0] rks [32]);
        logic [31:0] k [36];
        logic [31:0] x, t, ck;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) ck[31 - 8 * j -: 8] = 8'(((4 * i + j) * 7) % 256);
            x = k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck;
            t = {ref_sbox(x[31:24]), ref_sbox(x[23:16]), ref_sbox(x[15:8]), ref_sbox(x[7:0])};
            k[i + 4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            rks[i] = k[i + 4];
        end
    endtask

    task automatic tick();
        @(posedge K_clk);
        #1;
    endtask

    task automatic read_pair(input int idx, input logic [31:0] e1, input logic [31:0] e2,
                             input string tag);
        rd_idx = 6'(idx);
        tick();
        check({tag, ".rk1"}, rk1, e1);
        check({tag, ".rk2"}, rk2, e2);
    endtask

    // Start pulse, then verify the 32-edge busy/done profile; optional ignored re-pulse.
    task automatic run_expand(input logic [127:0] key, input int inject_at, input string tag);
        rd_idx  = 6'd5;
        key_in  = key;
        K_start = 1'b1;
        tick();
        K_start = 1'b0;
        check({tag, ".start_busy"}, 32'(K_busy), 1);
        check({tag, ".start_done"}, 32'(K_done), 0);
        for (int c = 1; c <= 32; c++) begin
            if (c == inject_at) begin
                key_in  = ZERO_KEY;
                K_start = 1'b1;
            end
            tick();
            K_start = 1'b0;
            check($sformatf("%s.busy@%0d", tag, c), 32'(K_busy), (c == 32) ? 0 : 1);
            check($sformatf("%s.done@%0d", tag, c), 32'(K_done), (c == 32) ? 1 : 0);
            check($sformatf("%s.rk1@%0d", tag, c), rk1, 0);
            check($sformatf("%s.rk2@%0d", tag, c), rk2, 0);
        end
    endtask

    task automatic sweep(input logic [31:0] rks [32], input string tag);
        for (int i = 0; i < 32; i++) begin
            read_pair(i, rks[i], rks[31 - i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        K_rst   = 1'b1;
        K_start = 1'b0;
        key_in  = '0;
        rd_idx  = '0;
        build_model(STD_KEY, exp_std);
        build_model(ZERO_KEY, exp_zero);

        #2;
        check("rst.busy", 32'(K_busy), 0);
        check("rst.done", 32'(K_done), 0);
        check("rst.rk1", rk1, 0);
        check("rst.rk2", rk2, 0);
        tick();
        K_rst = 1'b0;

        // Model sanity against the published SM4 example keys.
        check("model.rk0", exp_std[0], 32'hf12186f9);
        check("model.rk1", exp_std[1], 32'h41662b61);
        check("model.rk31", exp_std[31], 32'h9124a012);

        read_pair(5, 0, 0, "idle_read");
        check("idle.done", 32'(K_done), 0);

        // Standard vector with an ignored re-pulse (zero key) mid-expansion.
        run_expand(STD_KEY, 10, "std");
        read_pair(0, 32'hf12186f9, 32'h9124a012, "std.idx0");
        read_pair(1, 32'h41662b61, exp_std[30], "std.idx1");
        read_pair(31, 32'h9124a012, 32'hf12186f9, "std.idx31");
        sweep(exp_std, "std_sweep");
        read_pair(32, 0, 0, "std.idx32");
        read_pair(63, 0, 0, "std.idx63");

        // Restart from READY with the all-zero key.
        run_expand(ZERO_KEY, -1, "zero");
        sweep(exp_zero, "zero_sweep");

        // Back-to-back: new start on the first edge after K_done rises.
        run_expand(STD_KEY, -1, "b2b_a");
        run_expand(ZERO_KEY, -1, "b2b_b");
        read_pair(0, exp_zero[0], exp_zero[31], "b2b.idx0");
        read_pair(31, exp_zero[31], exp_zero[0], "b2b.idx31");

        // Asynchronous reset at expansion round 17.
        rd_idx  = 6'd5;
        key_in  = STD_KEY;
        K_start = 1'b1;
        tick();
        K_start = 1'b0;
        for (int c = 0; c < 17; c++) tick();
        check("mid.busy_before", 32'(K_busy), 1);
        @(negedge K_clk);
        K_rst = 1'b1;
        #1;
        check("mid.busy", 32'(K_busy), 0);
        check("mid.done", 32'(K_done), 0);
        check("mid.rk1", rk1, 0);
        check("mid.rk2", rk2, 0);
        tick();
        K_rst = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        check("post_rst.busy", 32'(K_busy), 0);
        check("post_rst.done", 32'(K_done), 0);
        read_pair(0, 0, 0, "post_rst.read");

        run_expand(STD_KEY, -1, "rerun");
        read_pair(0, 32'hf12186f9, 32'h9124a012, "rerun.idx0");
        read_pair(17, exp_std[17], exp_std[14], "rerun.idx17");

        // Asynchronous reset while serving non-zero keys.
        @(negedge K_clk);
        K_rst = 1'b1;
        #1;
        check("ready_rst.rk1", rk1, 0);
        check("ready_rst.rk2", rk2, 0);
        check("ready_rst.done", 32'(K_done), 0);
        tick();
        K_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
